// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decode operands and control into EX, turning load-use
// stalls and branch flushes into all-zero bubbles, holding on freeze, and counting events.
module id_ex_pipeline_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdu_stall,
  input  logic             flush_ex,
  input  logic             freeze,
  input  logic             valid_de,
  input  logic [XLEN-1:0]  pc_de,
  input  logic [XLEN-1:0]  rs1_data_de,
  input  logic [XLEN-1:0]  rs2_data_de,
  input  logic [XLEN-1:0]  imm_de,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic [4:0]       rd_de,
  input  logic             RUWr_de,
  input  logic             ALUASrc_de,
  input  logic             ALUBSrc_de,
  input  logic             DMWr_de,
  input  logic             DMRd_de,
  input  logic [3:0]       ALUOp_de,
  input  logic [4:0]       BrOp_de,
  input  logic [2:0]       DMCtrl_de,
  input  logic [1:0]       RUDataWrSrc_de,
  output logic             valid_ex,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  rs1_data_ex,
  output logic [XLEN-1:0]  rs2_data_ex,
  output logic [XLEN-1:0]  imm_ex,
  output logic [4:0]       rs1_ex,
  output logic [4:0]       rs2_ex,
  output logic [4:0]       rd_ex,
  output logic             RUWr_ex,
  output logic             ALUASrc_ex,
  output logic             ALUBSrc_ex,
  output logic             DMWr_ex,
  output logic             DMRd_ex,
  output logic [3:0]       ALUOp_ex,
  output logic [4:0]       BrOp_ex,
  output logic [2:0]       DMCtrl_ex,
  output logic [1:0]       RUDataWrSrc_ex,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BUS_W = 4 * XLEN + 35;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [BUS_W-1:0]  de_bus_s;
  logic [BUS_W-1:0]  ex_bus_nxt_s;
  logic [BUS_W-1:0]  ex_bus_r;
  logic [CNT_W-1:0]  bubble_cnt_nxt_s;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_nxt_s;
  logic [CNT_W-1:0]  flush_cnt_r;

  assign de_bus_s = {valid_de, pc_de, rs1_data_de, rs2_data_de, imm_de,
                     rs1_de, rs2_de, rd_de,
                     RUWr_de, ALUASrc_de, ALUBSrc_de, DMWr_de, DMRd_de,
                     ALUOp_de, BrOp_de, DMCtrl_de, RUDataWrSrc_de};

  // Next-state selection: a flush beats freeze so a killed instruction never survives it
  always_comb begin
    ex_bus_nxt_s     = ex_bus_r;
    bubble_cnt_nxt_s = bubble_cnt_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    if (flush_ex) begin
      ex_bus_nxt_s    = {BUS_W{1'b0}};
      flush_cnt_nxt_s = sat_inc(flush_cnt_r);
    end else if (freeze) begin
      ex_bus_nxt_s     = ex_bus_r;
      bubble_cnt_nxt_s = bubble_cnt_r;
      flush_cnt_nxt_s  = flush_cnt_r;
    end else if (hdu_stall) begin
      ex_bus_nxt_s     = {BUS_W{1'b0}};
      bubble_cnt_nxt_s = sat_inc(bubble_cnt_r);
    end else begin
      ex_bus_nxt_s = de_bus_s;
    end
  end

  // Pipeline and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bus_r     <= {BUS_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      ex_bus_r     <= ex_bus_nxt_s;
      bubble_cnt_r <= bubble_cnt_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
    end
  end

  assign {valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex,
          rs1_ex, rs2_ex, rd_ex,
          RUWr_ex, ALUASrc_ex, ALUBSrc_ex, DMWr_ex, DMRd_ex,
          ALUOp_ex, BrOp_ex, DMCtrl_ex, RUDataWrSrc_ex} = ex_bus_r;

  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register: directed scenarios plus randomized
// traffic against a cycle-level reference model of the priority and counter rules.
module tb_id_ex_pipeline_register;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int BUS_W   = 4 * XLEN + 35;

  logic clk = 1'b0;
  logic rst, hdu_stall, flush_ex, freeze, valid_de;
  logic [XLEN-1:0] pc_de, rs1_data_de, rs2_data_de, imm_de;
  logic [4:0] rs1_de, rs2_de, rd_de;
  logic RUWr_de, ALUASrc_de, ALUBSrc_de, DMWr_de, DMRd_de;
  logic [3:0] ALUOp_de;
  logic [4:0] BrOp_de;
  logic [2:0] DMCtrl_de;
  logic [1:0] RUDataWrSrc_de;

  logic valid_ex;
  logic [XLEN-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0] rs1_ex, rs2_ex, rd_ex;
  logic RUWr_ex, ALUASrc_ex, ALUBSrc_ex, DMWr_ex, DMRd_ex;
  logic [3:0] ALUOp_ex;
  logic [4:0] BrOp_ex;
  logic [2:0] DMCtrl_ex;
  logic [1:0] RUDataWrSrc_ex;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BUS_W-1:0] exp_bus;
  int exp_bub;
  int exp_fl;

  id_ex_pipeline_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .flush_ex(flush_ex), .freeze(freeze),
    .valid_de(valid_de), .pc_de(pc_de), .rs1_data_de(rs1_data_de), .rs2_data_de(rs2_data_de),
    .imm_de(imm_de), .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
    .RUWr_de(RUWr_de), .ALUASrc_de(ALUASrc_de), .ALUBSrc_de(ALUBSrc_de),
    .DMWr_de(DMWr_de), .DMRd_de(DMRd_de), .ALUOp_de(ALUOp_de), .BrOp_de(BrOp_de),
    .DMCtrl_de(DMCtrl_de), .RUDataWrSrc_de(RUDataWrSrc_de),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .RUWr_ex(RUWr_ex), .ALUASrc_ex(ALUASrc_ex), .ALUBSrc_ex(ALUBSrc_ex),
    .DMWr_ex(DMWr_ex), .DMRd_ex(DMRd_ex), .ALUOp_ex(ALUOp_ex), .BrOp_ex(BrOp_ex),
    .DMCtrl_ex(DMCtrl_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [BUS_W-1:0] de_fields();
    return {valid_de, pc_de, rs1_data_de, rs2_data_de, imm_de, rs1_de, rs2_de, rd_de,
            RUWr_de, ALUASrc_de, ALUBSrc_de, DMWr_de, DMRd_de,
            ALUOp_de, BrOp_de, DMCtrl_de, RUDataWrSrc_de};
  endfunction

  function automatic logic [BUS_W-1:0] ex_fields();
    return {valid_ex, pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex,
            RUWr_ex, ALUASrc_ex, ALUBSrc_ex, DMWr_ex, DMRd_ex,
            ALUOp_ex, BrOp_ex, DMCtrl_ex, RUDataWrSrc_ex};
  endfunction

  task automatic set_de_all(input logic v);
    valid_de = v; pc_de = {XLEN{v}}; rs1_data_de = {XLEN{v}}; rs2_data_de = {XLEN{v}};
    imm_de = {XLEN{v}}; rs1_de = {5{v}}; rs2_de = {5{v}}; rd_de = {5{v}};
    RUWr_de = v; ALUASrc_de = v; ALUBSrc_de = v; DMWr_de = v; DMRd_de = v;
    ALUOp_de = {4{v}}; BrOp_de = {5{v}}; DMCtrl_de = {3{v}}; RUDataWrSrc_de = {2{v}};
  endtask

  task automatic rand_de();
    valid_de = 1'($urandom); pc_de = $urandom; rs1_data_de = $urandom;
    rs2_data_de = $urandom; imm_de = $urandom;
    rs1_de = 5'($urandom); rs2_de = 5'($urandom); rd_de = 5'($urandom);
    RUWr_de = 1'($urandom); ALUASrc_de = 1'($urandom); ALUBSrc_de = 1'($urandom);
    DMWr_de = 1'($urandom); DMRd_de = 1'($urandom);
    ALUOp_de = 4'($urandom); BrOp_de = 5'($urandom); DMCtrl_de = 3'($urandom);
    RUDataWrSrc_de = 2'($urandom);
  endtask

  // Reference model: one clock edge applied by priority rst > flush > freeze > stall > load
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_bus = '0; exp_bub = 0; exp_fl = 0;
    end else if (flush_ex) begin
      exp_bus = '0; exp_fl = (exp_fl < CNT_MAX) ? exp_fl + 1 : CNT_MAX;
    end else if (freeze) begin
      exp_bus = exp_bus;
    end else if (hdu_stall) begin
      exp_bus = '0; exp_bub = (exp_bub < CNT_MAX) ? exp_bub + 1 : CNT_MAX;
    end else begin
      exp_bus = de_fields();
    end
    #1;
  endtask

  task automatic test_reset();
    set_de_all(1'b1);
    rst = 1'b1; hdu_stall = 1'b0; flush_ex = 1'b0; freeze = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (ex_fields() !== '0 || bubble_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_zero: got ex=%h bub=%0d fl=%0d required all zero", ex_fields(), bubble_cnt, flush_cnt);
      end
    end
    rst = 1'b0;
    set_de_all(1'b0);
    pc_de = 32'h0000_0010; valid_de = 1'b1;
    tick();
    n_checks++;
    if (pc_ex !== 32'h0000_0010 || valid_ex !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_load: got pc=%h valid=%b required pc=00000010 valid=1", pc_ex, valid_ex);
    end
  endtask

  task automatic test_load_use();
    set_de_all(1'b0);
    valid_de = 1'b1; pc_de = 32'h0000_0100; DMRd_de = 1'b1; RUWr_de = 1'b1; rd_de = 5'd5;
    rs1_de = 5'd2; RUDataWrSrc_de = 2'd1; DMCtrl_de = 3'd2;
    tick();
    n_checks++;
    if (DMRd_ex !== 1'b1 || rd_ex !== 5'd5 || ex_fields() !== exp_bus) begin
      n_fail++;
      $display("FAIL load_use_lw: got DMRd=%b rd=%0d required DMRd=1 rd=5", DMRd_ex, rd_ex);
    end
    set_de_all(1'b0);
    valid_de = 1'b1; pc_de = 32'h0000_0104; rs1_de = 5'd5; rs2_de = 5'd1; rd_de = 5'd6;
    RUWr_de = 1'b1; hdu_stall = 1'b1;
    tick();
    n_checks++;
    if (DMRd_ex !== 1'b0 || RUWr_ex !== 1'b0 || valid_ex !== 1'b0 || rd_ex !== 5'd0) begin
      n_fail++;
      $display("FAIL load_use_bubble: got DMRd=%b RUWr=%b valid=%b rd=%0d required 0 0 0 0", DMRd_ex, RUWr_ex, valid_ex, rd_ex);
    end
    n_checks++;
    if (bubble_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL load_use_cnt: got bub=%0d fl=%0d required bub=1 fl=0", bubble_cnt, flush_cnt);
    end
    hdu_stall = 1'b0;
    tick();
    n_checks++;
    if (rs1_ex !== 5'd5 || rd_ex !== 5'd6 || valid_ex !== 1'b1 || ex_fields() !== exp_bus) begin
      n_fail++;
      $display("FAIL load_use_add: got rs1=%0d rd=%0d valid=%b required rs1=5 rd=6 valid=1", rs1_ex, rd_ex, valid_ex);
    end
  endtask

  task automatic test_flush_vs_stall();
    rst = 1'b1; tick(); rst = 1'b0;
    rand_de(); valid_de = 1'b1;
    flush_ex = 1'b1; hdu_stall = 1'b1;
    tick();
    flush_ex = 1'b0; hdu_stall = 1'b0;
    n_checks++;
    if (ex_fields() !== '0 || flush_cnt !== 4'd1 || bubble_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_vs_stall: got ex=%h fl=%0d bub=%0d required ex=0 fl=1 bub=0", ex_fields(), flush_cnt, bubble_cnt);
    end
  endtask

  task automatic test_freeze();
    logic [CNT_W-1:0] bub_saved, fl_saved;
    set_de_all(1'b0); valid_de = 1'b1; pc_de = 32'h0000_0040;
    tick();
    bub_saved = bubble_cnt; fl_saved = flush_cnt;
    freeze = 1'b1; hdu_stall = 1'b1; pc_de = 32'h0000_0044;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc_ex !== 32'h0000_0040 || valid_ex !== 1'b1 || bubble_cnt !== bub_saved || flush_cnt !== fl_saved) begin
        n_fail++;
        $display("FAIL freeze_hold: got pc=%h valid=%b bub=%0d fl=%0d required pc=00000040 valid=1 bub=%0d fl=%0d",
                 pc_ex, valid_ex, bubble_cnt, flush_cnt, bub_saved, fl_saved);
      end
    end
    flush_ex = 1'b1;
    tick();
    n_checks++;
    if (valid_ex !== 1'b0 || ex_fields() !== '0 || flush_cnt !== fl_saved + 4'd1 || bubble_cnt !== bub_saved) begin
      n_fail++;
      $display("FAIL freeze_flush: got valid=%b fl=%0d bub=%0d required valid=0 fl=%0d bub=%0d",
               valid_ex, flush_cnt, bubble_cnt, fl_saved + 4'd1, bub_saved);
    end
    flush_ex = 1'b0; freeze = 1'b0; hdu_stall = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    hdu_stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      rand_de();
      tick();
      n_checks++;
      if (bubble_cnt !== 4'((i > CNT_MAX) ? CNT_MAX : i) || valid_ex !== 1'b0) begin
        n_fail++;
        $display("FAIL saturation: cycle %0d got bub=%0d valid=%b required bub=%0d valid=0",
                 i, bubble_cnt, valid_ex, (i > CNT_MAX) ? CNT_MAX : i);
      end
    end
    hdu_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    hdu_stall = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    hdu_stall = 1'b0; rand_de(); valid_de = 1'b1;
    tick();
    freeze = 1'b1; hdu_stall = 1'b1;
    tick();
    n_checks++;
    if (valid_ex !== 1'b1 || bubble_cnt !== 4'd7) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got valid=%b bub=%0d required valid=1 bub=7", valid_ex, bubble_cnt);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (ex_fields() !== '0 || bubble_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got ex=%h bub=%0d fl=%0d required all zero", ex_fields(), bubble_cnt, flush_cnt);
    end
    rst = 1'b0; freeze = 1'b0; hdu_stall = 1'b0; rand_de();
    tick();
    n_checks++;
    if (ex_fields() !== exp_bus || ex_fields() !== de_fields()) begin
      n_fail++;
      $display("FAIL reset_mid_load: got ex=%h required %h", ex_fields(), exp_bus);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_de();
      rst       = ($urandom_range(39, 0) == 0);
      flush_ex  = ($urandom_range(7, 0) == 0);
      freeze    = ($urandom_range(5, 0) == 0);
      hdu_stall = ($urandom_range(3, 0) == 0);
      tick();
      n_checks++;
      if (ex_fields() !== exp_bus || bubble_cnt !== 4'(exp_bub) || flush_cnt !== 4'(exp_fl)) begin
        n_fail++;
        $display("FAIL random[%0d]: got ex=%h bub=%0d fl=%0d required ex=%h bub=%0d fl=%0d",
                 i, ex_fields(), bubble_cnt, flush_cnt, exp_bus, exp_bub, exp_fl);
      end
    end
    rst = 1'b0; flush_ex = 1'b0; freeze = 1'b0; hdu_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hdu_stall = 1'b0; flush_ex = 1'b0; freeze = 1'b0;
    set_de_all(1'b0);
    exp_bus = '0; exp_bub = 0; exp_fl = 0;
    test_reset();
    test_load_use();
    test_flush_vs_stall();
    test_freeze();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Captures the decode-stage operands and control word into the EX stage.
- Produces rd_ex and DMRd_ex, the signals the load-use hazard check compares against the decode-stage source registers.
- Converts that check's stall request into a bubble. Also handles branch/jump flush and whole-pipe freeze, and keeps saturating bubble/flush event counters for performance debug.

Parameters:
- XLEN, 32, datapath width of pc, register-file operands and immediate
- CNT_W, 16, width of the bubble and flush event counters

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- hdu_stall  input  1  load-use stall request from hazard detection; insert bubble
- flush_ex  input  1  branch/jump taken in EX; kill instruction entering EX
- freeze  input  1  global pipe freeze (data-memory busy); hold all contents
- valid_de  input  1  decode stage holds a real instruction
- pc_de  input  XLEN  decode pc
- rs1_data_de, rs2_data_de  input  XLEN  register-file read data
- imm_de  input  XLEN  decoded immediate
- rs1_de, rs2_de, rd_de  input  5  register indices
- RUWr_de, ALUASrc_de, ALUBSrc_de, DMWr_de, DMRd_de  input  1  control bits
- ALUOp_de  input  4  ALU operation
- BrOp_de  input  5  branch operation
- DMCtrl_de  input  3  memory access size/sign
- RUDataWrSrc_de  input  2  writeback source select
- *_ex outputs  output  same widths  registered copies of every *_de field above, plus valid_ex (1 bit)
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset
- flush_cnt  output  CNT_W  number of flushes applied since reset

Behaviour:
- Reset (rst=1 at edge):
  - every *_ex output is 0, valid_ex=0, bubble_cnt=0, flush_cnt=0.
  - rst overrides all other inputs in the same cycle.
- Per-edge priority (first match wins): rst > flush_ex > freeze > hdu_stall > load.
- flush_ex=1:
  - Load a bubble: valid_ex=0, RUWr_ex=DMWr_ex=DMRd_ex=0, BrOp_ex=0, rd_ex=0.
  - All other fields also 0.
  - flush_cnt increments.
  - Applies even when freeze=1 (the killed instruction must not survive a freeze).
- freeze=1 (no flush): every register, including the counters, holds its value. hdu_stall is ignored.
- hdu_stall=1 (no flush, no freeze):
  - Load a bubble exactly as for flush.
  - bubble_cnt increments; flush_cnt unchanged.
  - The upstream IF/ID hold is done elsewhere; this block only inserts one bubble per asserted cycle.
- Load (none of the above): every *_ex field takes its *_de value; valid_ex=valid_de. No zeroing even when valid_de=0.
- Latency: exactly 1 cycle from decode input to EX output. No combinational path from any input to any output.
- Bubble encoding: all-zero control word.
  - Guarantees DMRd_ex=0, so hazard detection deasserts on the cycle after a bubble.
  - rd_ex=0 ensures bubble never matches a forwarding/hazard compare against x0-free sources.
- Counters:
  - Unsigned, increment by 1, saturate at 2^CNT_W-1; no wrap.
  - Simultaneous flush_ex and hdu_stall count only as a flush.
- Back-to-back hdu_stall on N cycles: N bubbles, bubble_cnt += N.
- Reset mid-freeze or mid-stall clears everything on that edge; the next cycle behaves as a normal load.

Test Plan:
- Reset: rst=1 for 2 cycles with all *_de=all-ones -> all *_ex=0, valid_ex=0, counters 0; first edge after rst=0 loads pc_de=0x0000_0010 -> pc_ex=0x0000_0010 one cycle later.
- Load-use: load lw x5 (DMRd_de=1, rd_de=5) then assert hdu_stall=1 one cycle with add x6,x5,x1 at decode -> next cycle DMRd_ex=0, RUWr_ex=0, valid_ex=0, rd_ex=0, bubble_cnt=1; following cycle add loads with rs1_ex=5.
- Flush vs stall: flush_ex=1 and hdu_stall=1 same cycle -> bubble, flush_cnt=1, bubble_cnt=0.
- Freeze: load pc_de=0x40, then freeze=1 for 3 cycles with pc_de=0x44 and hdu_stall=1 -> pc_ex stays 0x40, counters unchanged; freeze+flush_ex -> valid_ex=0, flush_cnt+1.
- Saturation: CNT_W=4, hdu_stall held 20 cycles -> bubble_cnt reaches 15 and stays 15.
- Reset mid-operation: rst=1 during freeze with valid_ex=1, bubble_cnt=7 -> next cycle all outputs 0, counters 0.
